// File: rtl/msi_bus_pkg.sv
// Shared constants for the two-cache MSI snoop bus arbiter.
// Bus request types, MSI line states and arbiter state encoding.
package msi_bus_pkg;

    localparam logic [1:0] BUS_INVALIDATE = 2'b00;
    localparam logic [1:0] BUS_WRITE_MISS = 2'b01;
    localparam logic [1:0] BUS_READ_MISS  = 2'b10;

    localparam logic [1:0] MSI_INVALID  = 2'b00;
    localparam logic [1:0] MSI_MODIFIED = 2'b01;
    localparam logic [1:0] MSI_SHARED   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SNOOP = 3'd1,
        ST_WB    = 3'd2,
        ST_FETCH = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/msi_rr_pick2.sv
// Two-way round-robin pick: on a tie the cache that did not own
// the bus last wins.
module msi_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = (req == 2'b11) ? ~last_owner : req[1];
    end

endmodule

// File: rtl/msi_bus_arbiter.sv
// Snoop bus arbiter for two MSI caches: arbitrate, broadcast, memory timing.
// Define MSI_BUS_ARB_STATS_EN to add grant and peer-hit statistics counters.
module msi_bus_arbiter
    import msi_bus_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        req_type0,
    input  logic [1:0]        req_type1,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    output logic [1:0]        grant,
    output logic              bus_valid,
    output logic [1:0]        bus_requests,
    output logic [ADDR_W-1:0] bus_addr,
    input  logic              snoop_abort,
    input  logic              snoop_wb,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              data_from_peer,
    output logic [1:0]        done
`ifdef MSI_BUS_ARB_STATS_EN
    ,
    output logic [15:0]       grant_cnt0,
    output logic [15:0]       grant_cnt1,
    output logic [15:0]       peer_hit_cnt
`endif
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    arb_state_t        state;
    logic              last_owner;
    logic              owner;
    logic [3:0]        cnt;
    logic              pick_winner;
    logic              pick_valid;
    logic [1:0]        pick_type;
    logic [ADDR_W-1:0] pick_addr;

    msi_rr_pick2 u_pick (
        .req        (req),
        .last_owner (last_owner),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    assign pick_type = pick_winner ? req_type1 : req_type0;
    assign pick_addr = pick_winner ? req_addr1 : req_addr0;

    // bus_requests/bus_addr double as the latched type/address during SNOOP
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            last_owner     <= 1'b1;
            owner          <= 1'b0;
            cnt            <= 4'd0;
            grant          <= 2'b00;
            bus_valid      <= 1'b0;
            bus_requests   <= 2'b00;
            bus_addr       <= '0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            data_from_peer <= 1'b0;
            done           <= 2'b00;
`ifdef MSI_BUS_ARB_STATS_EN
            grant_cnt0     <= 16'd0;
            grant_cnt1     <= 16'd0;
            peer_hit_cnt   <= 16'd0;
`endif
        end else begin
            bus_valid      <= 1'b0;
            bus_requests   <= 2'b00;
            bus_addr       <= '0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            data_from_peer <= 1'b0;
            done           <= 2'b00;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner        <= pick_winner;
                        grant        <= onehot2(pick_winner);
                        bus_valid    <= 1'b1;
                        bus_requests <= pick_type;
                        bus_addr     <= pick_addr;
                        state        <= ST_SNOOP;
                    end
                end
                ST_SNOOP: begin
                    cnt <= LAT_LOAD;
                    if (bus_requests == BUS_INVALIDATE) begin
                        done  <= onehot2(owner);
                        state <= ST_DONE;
                    end else if (snoop_wb) begin
                        mem_wr <= 1'b1;
                        state  <= ST_WB;
                    end else if (snoop_abort) begin
                        done           <= onehot2(owner);
                        data_from_peer <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        mem_rd <= 1'b1;
                        state  <= ST_FETCH;
                    end
                end
                ST_WB: begin
                    if (cnt == 4'd0) begin
                        done           <= onehot2(owner);
                        data_from_peer <= 1'b1;
                        state          <= ST_DONE;
                    end else begin
                        cnt    <= cnt - 4'd1;
                        mem_wr <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (cnt == 4'd0) begin
                        done  <= onehot2(owner);
                        state <= ST_DONE;
                    end else begin
                        cnt    <= cnt - 4'd1;
                        mem_rd <= 1'b1;
                    end
                end
                ST_DONE: begin
                    last_owner <= owner;
                    grant      <= 2'b00;
                    state      <= ST_IDLE;
`ifdef MSI_BUS_ARB_STATS_EN
                    if (owner)
                        grant_cnt1 <= grant_cnt1 + 16'd1;
                    else
                        grant_cnt0 <= grant_cnt0 + 16'd1;
                    if (data_from_peer)
                        peer_hit_cnt <= peer_hit_cnt + 16'd1;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msi_bus_arbiter.sv
// Self-checking bench for msi_bus_arbiter: transaction-level model plus
// directed vectors. Define MSI_BUS_ARB_STATS_EN to cover the statistics.
module tb_msi_bus_arbiter;

    localparam int AW = 10;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [1:0]    req_type0, req_type1;
    logic [AW-1:0] req_addr0, req_addr1;
    logic [1:0]    grant;
    logic          bus_valid;
    logic [1:0]    bus_requests;
    logic [AW-1:0] bus_addr;
    logic          snoop_abort, snoop_wb;
    logic          mem_rd, mem_wr;
    logic          data_from_peer;
    logic [1:0]    done;
`ifdef MSI_BUS_ARB_STATS_EN
    logic [15:0]   grant_cnt0, grant_cnt1, peer_hit_cnt;
`endif

    int nchk = 0;
    int nfail = 0;

    msi_bus_arbiter #(.ADDR_W(AW), .MEM_LAT(L)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_type0      (req_type0),
        .req_type1      (req_type1),
        .req_addr0      (req_addr0),
        .req_addr1      (req_addr1),
        .grant          (grant),
        .bus_valid      (bus_valid),
        .bus_requests   (bus_requests),
        .bus_addr       (bus_addr),
        .snoop_abort    (snoop_abort),
        .snoop_wb       (snoop_wb),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .data_from_peer (data_from_peer),
        .done           (done)
`ifdef MSI_BUS_ARB_STATS_EN
        ,
        .grant_cnt0     (grant_cnt0),
        .grant_cnt1     (grant_cnt1),
        .peer_hit_cnt   (peer_hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] oh(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

    // Transaction model: a transaction starts in IDLE cycle cs; SNOOP is
    // cycle cs+1 and DONE is cycle cs+m_total (2, or 2+L with memory).
    bit          m_chk = 0;
    bit          m_active = 0;
    int          cyc = 0;
    int          cs = 0;
    int          m_total = 0;
    int          m_kind = 0;
    bit          m_peer = 0;
    logic        m_owner, m_last;
    logic [1:0]  m_type;
    logic [AW-1:0] m_addr;
    logic [15:0] m_g0, m_g1, m_ph;

    always @(posedge clk) begin
        int n;
        n = cyc;
        if (rst) begin
            m_chk = 1; m_active = 0; m_last = 1'b1;
            m_g0 = 0; m_g1 = 0; m_ph = 0;
        end else if (m_active) begin
            if (n - cs == 1) begin
                if (m_type == 2'b00) begin
                    m_kind = 0; m_total = 2; m_peer = 0;
                end else if (snoop_wb) begin
                    m_kind = 1; m_total = 2 + L; m_peer = 1;
                end else if (snoop_abort) begin
                    m_kind = 0; m_total = 2; m_peer = 1;
                end else begin
                    m_kind = 2; m_total = 2 + L; m_peer = 0;
                end
            end else if (n - cs == m_total) begin
                m_active = 0;
                m_last = m_owner;
                if (m_owner) m_g1++; else m_g0++;
                if (m_peer) m_ph++;
            end
        end else if (req != 2'b00) begin
            m_owner  = (req == 2'b11) ? ~m_last : req[1];
            m_type   = m_owner ? req_type1 : req_type0;
            m_addr   = m_owner ? req_addr1 : req_addr0;
            m_active = 1;
            cs       = n;
            m_total  = 0;
        end
        cyc = n + 1;
    end

    always @(negedge clk) begin
        int r;
        logic [7:0] ev;
        if (m_chk) begin
            ev = '0;
            r = cyc - cs;
            if (m_active && r >= 1) begin
                ev[7:6] = oh(m_owner);
                ev[5] = (r == 1);
                if (r >= 2) begin
                    ev[4] = (m_kind == 2) && (r <= 1 + L);
                    ev[3] = (m_kind == 1) && (r <= 1 + L);
                    ev[2] = (r == m_total) && m_peer;
                    ev[1:0] = (r == m_total) ? oh(m_owner) : 2'b00;
                end
            end
            check("cycle_outputs",
                  {grant, bus_valid, mem_rd, mem_wr, data_from_peer, done}, ev);
            if (ev[5])
                check("snoop_bus", {bus_requests, bus_addr}, {m_type, m_addr});
`ifdef MSI_BUS_ARB_STATS_EN
            check("stats", {grant_cnt0, grant_cnt1}, {m_g0, m_g1});
            check("stats_peer", peer_hit_cnt, m_ph);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [1:0] r, input logic [1:0] t0,
                           input logic [AW-1:0] a0, input logic [1:0] t1,
                           input logic [AW-1:0] a1, input logic wb, ab,
                           output int lat, output int nrd, output int nwr,
                           output logic [1:0] dn, output logic dfp,
                           output logic [12:0] snp);
        req = r; req_type0 = t0; req_addr0 = a0;
        req_type1 = t1; req_addr1 = a1;
        snoop_wb = wb; snoop_abort = ab;
        lat = 0; nrd = 0; nwr = 0; dn = 0; dfp = 0; snp = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 1) begin
                req = 2'b00;
                snp = {bus_valid, bus_requests, bus_addr};
            end
            if (i == 2) begin
                snoop_wb = 0; snoop_abort = 0;
            end
            nrd += int'(mem_rd);
            nwr += int'(mem_wr);
            if (done != 2'b00) begin
                lat = i; dn = done; dfp = data_from_peer;
                break;
            end
        end
        step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (grant == 2'b00) break;
            step();
        end
        check("idle_timeout", {30'd0, grant}, 32'd0);
    endtask

    initial begin
        int lat, nrd, nwr, k, dsum;
        logic [1:0] dn;
        logic dfp;
        logic [12:0] snp;
        logic [1:0] g [8];

        rst = 1; req = 0; req_type0 = 0; req_type1 = 0;
        req_addr0 = 0; req_addr1 = 0; snoop_abort = 0; snoop_wb = 0;
        for (int i = 0; i < 8; i++) g[i] = 2'b00;
        step(); step();
        check("reset_outputs",
              {grant, bus_valid, bus_requests, bus_addr, mem_rd, mem_wr,
               data_from_peer, done}, 32'd0);
        rst = 0;

        // tie in the first IDLE after reset, req held at 11, peer hits
        req = 2'b11; req_type0 = 2'b10; req_addr0 = 10'h021;
        req_type1 = 2'b10; req_addr1 = 10'h032; snoop_abort = 1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus_valid && k < 8) begin
                g[k] = grant; k++;
            end
        end
        req = 2'b00; snoop_abort = 0;
        check("rr_first", {30'd0, g[0]}, 32'h1);
        check("rr_second", {30'd0, g[1]}, 32'h2);
        check("rr_third", {30'd0, g[2]}, 32'h1);
        wait_idle();

        // read miss, memory fetch
        run_txn(2'b01, 2'b10, 10'h015, 2'b10, 10'h3c3, 0, 0,
                lat, nrd, nwr, dn, dfp, snp);
        check("rd_snoop", {19'd0, snp}, {19'd0, 1'b1, 2'b10, 10'h015});
        check("rd_latency", lat, 4);
        check("rd_memrd_cycles", nrd, 2);
        check("rd_done", {29'd0, dn, dfp}, {29'd0, 2'b01, 1'b0});

        // cache 1 write miss with a write-back from the peer
        run_txn(2'b10, 2'b10, 10'h011, 2'b01, 10'h02a, 1, 0,
                lat, nrd, nwr, dn, dfp, snp);
        check("wb_snoop", {19'd0, snp}, {19'd0, 1'b1, 2'b01, 10'h02a});
        check("wb_memwr_cycles", nwr, L);
        check("wb_memrd_cycles", nrd, 0);
        check("wb_done", {29'd0, dn, dfp}, {29'd0, 2'b10, 1'b1});

        // invalidate outranks snoop_abort
        run_txn(2'b01, 2'b00, 10'h007, 2'b10, 10'h000, 0, 1,
                lat, nrd, nwr, dn, dfp, snp);
        check("inv_latency", lat, 2);
        check("inv_done", {29'd0, dn, dfp}, {29'd0, 2'b01, 1'b0});

        // reset in the middle of FETCH
        req = 2'b01; req_type0 = 2'b10; req_addr0 = 10'h099;
        step();
        req = 2'b00;
        step();
        check("fetch_before_rst", {31'd0, mem_rd}, 32'd1);
        rst = 1;
        step();
        check("rst_in_fetch",
              {grant, bus_valid, bus_requests, bus_addr, mem_rd, mem_wr,
               data_from_peer, done}, 32'd0);
        rst = 0;
        dsum = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            dsum += int'(done != 2'b00);
        end
        check("no_done_after_rst", dsum, 0);

        // three cache 0 transactions and one cache 1 peer hit
        run_txn(2'b01, 2'b10, 10'h100, 2'b00, 10'h000, 0, 0,
                lat, nrd, nwr, dn, dfp, snp);
        check("s_fetch_a", lat, 4);
        run_txn(2'b01, 2'b00, 10'h101, 2'b00, 10'h000, 0, 0,
                lat, nrd, nwr, dn, dfp, snp);
        check("s_inv", lat, 2);
        run_txn(2'b01, 2'b01, 10'h102, 2'b00, 10'h000, 0, 0,
                lat, nrd, nwr, dn, dfp, snp);
        check("s_fetch_b", lat, 4);
        run_txn(2'b10, 2'b00, 10'h000, 2'b10, 10'h1ff, 0, 1,
                lat, nrd, nwr, dn, dfp, snp);
        check("s_peer_hit", {29'd0, dn, dfp}, {29'd0, 2'b10, 1'b1});
        check("s_peer_latency", lat, 2);
`ifdef MSI_BUS_ARB_STATS_EN
        check("grant_cnt0", grant_cnt0, 3);
        check("grant_cnt1", grant_cnt1, 1);
        check("peer_hit_cnt", peer_hit_cnt, 1);
`endif
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
